stw_controller: RTL and testbench

Stop-the-world (STW) test initiator for the systolic MAC array. It drives the broadcast STW test bus into every PE: operand and expected registers, load strobe and start pulse. It then collects each PE's `STW_complete`/`STW_result_out` and builds a sticky per-PE fault map for the BISR repair logic. Test vectors come from an on-chip LFSR. Expected results are computed internally with the PE's truncated MAC arithmetic.

---
 rtl/stw_controller.sv | 193 +++++++++++++++++++
 tb/tb_stw_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stw_controller.sv
// Stop-the-world self-test initiator for the systolic MAC array.
// Broadcasts MAC test vectors to every PE and accumulates a sticky per-PE fault map.
module stw_controller #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned NUM_PE      = 16,
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned TIMEOUT     = 8,
    parameter int unsigned PERIOD      = 0,
    parameter logic [31:0] SEED        = 32'hACE1_2468
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 test_req,
    input  logic                 clear_faults,
    output logic                 test_busy,
    output logic                 test_done,
    output logic [NUM_PE-1:0]    fault_map,
    output logic                 any_fault,
    output logic                 STW_test_load_en,
    output logic [WORD_SIZE-1:0] STW_mult_op1,
    output logic [WORD_SIZE-1:0] STW_mult_op2,
    output logic [WORD_SIZE-1:0] STW_add_op,
    output logic [WORD_SIZE-1:0] STW_expected,
    output logic                 STW_start,
    input  logic [NUM_PE-1:0]    STW_complete,
    input  logic [NUM_PE-1:0]    STW_result_out
);

    localparam int unsigned VecIdxW   = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int unsigned WaitCntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned PerCntW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [31:0] LfsrTaps  = 32'h8020_0003;
    localparam logic [VecIdxW-1:0]  LastVec  = VecIdxW'(NUM_VECTORS - 1);
    localparam logic [WaitCntW-1:0] LastWait = WaitCntW'(TIMEOUT - 1);
    localparam logic [PerCntW-1:0]  LastIdle = PerCntW'(PERIOD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StArm,
        StWait,
        StDone
    } state_e;

    state_e               r_state;
    logic [31:0]          r_lfsr;
    logic [VecIdxW-1:0]   r_vec_idx;
    logic [WaitCntW-1:0]  r_wait_cnt;
    logic [PerCntW-1:0]   r_period_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [NUM_PE-1:0]    r_fault_map;
    logic                 r_any_fault;
    logic                 r_load_en;
    logic                 r_start;
    logic [WORD_SIZE-1:0] r_op1;
    logic [WORD_SIZE-1:0] r_op2;
    logic [WORD_SIZE-1:0] r_add;
    logic [WORD_SIZE-1:0] r_exp;

    logic                 w_period_hit;
    logic                 w_trigger;
    logic                 w_all_complete;
    logic                 w_wait_exit;
    logic                 w_last_vec;
    logic [31:0]          w_lfsr_step;
    logic [31:0]          w_lfsr_next;
    logic [WORD_SIZE-1:0] w_op1;
    logic [WORD_SIZE-1:0] w_op2;
    logic [WORD_SIZE-1:0] w_add;
    logic [WORD_SIZE-1:0] w_exp;

    assign w_period_hit   = (PERIOD != 0) && (r_period_cnt == LastIdle);
    assign w_trigger      = test_req || w_period_hit;
    assign w_all_complete = &STW_complete;
    assign w_wait_exit    = w_all_complete || (r_wait_cnt == LastWait);
    assign w_last_vec     = (r_vec_idx == LastVec);

    // Galois step, shifting right; vector 0 is fixed and does not consume an LFSR state.
    assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LfsrTaps : 32'h0);
    assign w_lfsr_next = (r_vec_idx != '0) ? w_lfsr_step : r_lfsr;

    // The next vector is always LFSR-based, built from the post-advance state.
    assign w_op1 = w_lfsr_next[WORD_SIZE-1:0];
    assign w_op2 = w_lfsr_next[31:32-WORD_SIZE];
    assign w_add = w_lfsr_next[WORD_SIZE+7:8];
    assign w_exp = w_op1 * w_op2 + w_add;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_lfsr       <= SEED;
            r_vec_idx    <= '0;
            r_wait_cnt   <= '0;
            r_period_cnt <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault_map  <= '0;
            r_any_fault  <= 1'b0;
            r_load_en    <= 1'b0;
            r_start      <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_add        <= '0;
            r_exp        <= '0;
        end else begin
            r_load_en   <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_any_fault <= |r_fault_map;

            unique case (r_state)
                StIdle: begin
                    if (clear_faults) begin
                        r_fault_map <= '0;
                    end
                    if (w_trigger) begin
                        r_state      <= StLoad;
                        r_busy       <= 1'b1;
                        r_load_en    <= 1'b1;
                        r_period_cnt <= '0;
                        // Unit vector: exposes multiplier stuck-at faults directly.
                        r_op1        <= WORD_SIZE'(1);
                        r_op2        <= WORD_SIZE'(1);
                        r_add        <= '0;
                        r_exp        <= WORD_SIZE'(1);
                    end else if (PERIOD != 0) begin
                        r_period_cnt <= r_period_cnt + 1'b1;
                    end
                end

                StLoad: begin
                    r_state <= StStart;
                    r_start <= 1'b1;
                end

                StStart: begin
                    r_state    <= StArm;
                    r_wait_cnt <= '0;
                end

                // PEs may still present a stale complete here, so nothing is sampled.
                StArm: begin
                    r_state <= StWait;
                end

                StWait: begin
                    if (w_wait_exit) begin
                        r_fault_map <= r_fault_map | ~STW_result_out | ~STW_complete;
                        r_lfsr      <= w_lfsr_next;
                        if (w_last_vec) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StLoad;
                            r_load_en <= 1'b1;
                            r_vec_idx <= r_vec_idx + 1'b1;
                            r_op1     <= w_op1;
                            r_op2     <= w_op2;
                            r_add     <= w_add;
                            r_exp     <= w_exp;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                StDone: begin
                    r_state   <= StIdle;
                    r_busy    <= 1'b0;
                    r_vec_idx <= '0;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign test_busy        = r_busy;
    assign test_done        = r_done;
    assign fault_map        = r_fault_map;
    assign any_fault        = r_any_fault;
    assign STW_test_load_en = r_load_en;
    assign STW_start        = r_start;
    assign STW_mult_op1     = r_op1;
    assign STW_mult_op2     = r_op2;
    assign STW_add_op       = r_add;
    assign STW_expected     = r_exp;

endmodule

// File: tb/tb_stw_controller.sv
// Self-checking bench for stw_controller: PE models on the STW bus, a behavioural
// vector/fault model, directed scenarios and randomized back-to-back sweeps.
module tb_stw_controller;

    localparam int unsigned WS   = 16;
    localparam int unsigned NPE  = 4;
    localparam int unsigned NV   = 4;
    localparam int unsigned TO   = 8;
    localparam int unsigned PER  = 50;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int HEALTHY_LAT   = 4 * NV;
    localparam int STUCK_LAT     = 4 * NV + (TO - 1) * NV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           test_req = 1'b0;
    logic           clear_faults = 1'b0;
    logic           test_busy, test_done, any_fault, load_en, start;
    logic [NPE-1:0] fault_map, complete, result;
    logic [WS-1:0]  op1, op2, addv, expv;

    logic           p_req = 1'b0;
    logic           p_busy, p_done, p_any, p_load, p_start;
    logic [NPE-1:0] p_fault, p_complete, p_result;
    logic [WS-1:0]  p_op1, p_op2, p_add, p_exp;

    stw_controller #(
        .WORD_SIZE(WS), .NUM_PE(NPE), .NUM_VECTORS(NV), .TIMEOUT(TO), .PERIOD(0), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .test_req(test_req), .clear_faults(clear_faults),
        .test_busy(test_busy), .test_done(test_done), .fault_map(fault_map),
        .any_fault(any_fault), .STW_test_load_en(load_en), .STW_mult_op1(op1),
        .STW_mult_op2(op2), .STW_add_op(addv), .STW_expected(expv), .STW_start(start),
        .STW_complete(complete), .STW_result_out(result)
    );

    stw_controller #(
        .WORD_SIZE(WS), .NUM_PE(NPE), .NUM_VECTORS(NV), .TIMEOUT(TO), .PERIOD(PER), .SEED(SEED)
    ) dut_p (
        .clk(clk), .rst(rst), .test_req(p_req), .clear_faults(1'b0),
        .test_busy(p_busy), .test_done(p_done), .fault_map(p_fault),
        .any_fault(p_any), .STW_test_load_en(p_load), .STW_mult_op1(p_op1),
        .STW_mult_op2(p_op2), .STW_add_op(p_add), .STW_expected(p_exp), .STW_start(p_start),
        .STW_complete(p_complete), .STW_result_out(p_result)
    );

    // PE models: busy for one cycle after start, pass iff the broadcast MAC checks out.
    logic           pe_busy, p_pe_busy;
    logic [NPE-1:0] stuck_mask, bad_mask;
    int             bad_vec, cur_vec;
    logic [31:0]    full_mac;
    logic           arith_ok;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_busy   <= 1'b0;
            p_pe_busy <= 1'b0;
            cur_vec   <= -1;
        end else begin
            pe_busy   <= start;
            p_pe_busy <= p_start;
            if (test_done) cur_vec <= -1;
            else if (load_en) cur_vec <= cur_vec + 1;
        end
    end

    assign full_mac = 32'(op1) * 32'(op2) + 32'(addv);
    assign arith_ok = (full_mac[WS-1:0] == expv);

    always_comb begin
        complete = '0;
        result   = '0;
        for (int i = 0; i < NPE; i++) begin
            complete[i] = !pe_busy && !stuck_mask[i];
            result[i]   = arith_ok && !(bad_mask[i] && (cur_vec == bad_vec));
        end
    end

    assign p_complete = {NPE{~p_pe_busy}};
    assign p_result   = '1;

    // Reference model state
    logic [31:0]    m_lfsr;
    int             m_idx;
    logic [NPE-1:0] m_fault;
    int             n_vec, n_err;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (((l % 2) == 1) ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_vector();
        longint e1, e2, ea, ee, modv;
        modv = longint'(1) << WS;
        if (m_idx == 0) begin
            e1 = 1; e2 = 1; ea = 0;
        end else begin
            e1 = longint'(m_lfsr) % modv;
            e2 = longint'(m_lfsr) >> (32 - WS);
            ea = (longint'(m_lfsr) >> 8) % modv;
            m_lfsr = lfsr_next(m_lfsr);
        end
        ee = (e1 * e2 + ea) % modv;
        chk("vec_op1", 32'(op1), 32'(e1));
        chk("vec_op2", 32'(op2), 32'(e2));
        chk("vec_add", 32'(addv), 32'(ea));
        chk("vec_expected", 32'(expv), 32'(ee));
        m_idx = (m_idx + 1) % NV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (load_en) check_vector();
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (lat < budget && !test_done) begin
            tick();
            lat++;
        end
        chk("done_seen", 32'(test_done), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(test_busy), 0);
        chk("rst_done", 32'(test_done), 0);
        chk("rst_fault_map", 32'(fault_map), 0);
        chk("rst_any_fault", 32'(any_fault), 0);
        chk("rst_load_en", 32'(load_en), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_op1", 32'(op1), 0);
        chk("rst_op2", 32'(op2), 0);
        chk("rst_add", 32'(addv), 0);
        chk("rst_expected", 32'(expv), 0);
    endtask

    task automatic run_sweep(input bit keep_req, input bit clr_busy, input int want_lat);
        int lat;
        test_req = 1'b1;
        tick();
        test_req     = keep_req;
        clear_faults = clr_busy;
        chk("trig_load_en", 32'(load_en), 1);
        chk("trig_busy", 32'(test_busy), 1);
        wait_done(200, lat);
        clear_faults = 1'b0;
        chk("done_latency", 32'(lat), 32'(want_lat));
        chk("fault_map", 32'(fault_map), 32'(m_fault));
        tick();
        chk("idle_busy", 32'(test_busy), 0);
        chk("done_pulse", 32'(test_done), 0);
        chk("any_fault", 32'(any_fault), 32'(|m_fault));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        n_vec = 0;
        n_err = 0;
        m_lfsr = SEED;
        m_idx = 0;
        m_fault = '0;
        stuck_mask = '0;
        bad_mask = '0;
        bad_vec = 0;

        #1 rst = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Periodic trigger after PER idle cycles; a request while busy is dropped
        for (int i = 0; i < int'(PER) - 1; i++) begin
            tick();
            chk("per_wait_idle", 32'(p_busy), 0);
        end
        tick();
        chk("per_start_busy", 32'(p_busy), 1);
        chk("per_start_load", 32'(p_load), 1);
        lat = 0;
        for (int i = 0; i < 200 && !p_done; i++) begin
            p_req = (i == 3);
            tick();
            lat++;
        end
        p_req = 1'b0;
        chk("per_done_seen", 32'(p_done), 1);
        chk("per_latency", 32'(lat), 32'(HEALTHY_LAT));
        tick();
        chk("per_back_idle", 32'(p_busy), 0);
        for (int i = 0; i < int'(PER) - 1; i++) begin
            tick();
            chk("per_no_extra", 32'(p_busy), 0);
        end
        tick();
        chk("per_restart", 32'(p_busy), 1);
        chk("main_still_idle", 32'(test_busy), 0);

        // Healthy sweep
        run_sweep(1'b0, 1'b0, HEALTHY_LAT);

        // Bad result on PE2 at vector 1, then stickiness and clears
        bad_mask = 4'b0100;
        bad_vec  = 1;
        m_fault |= 4'b0100;
        run_sweep(1'b0, 1'b0, HEALTHY_LAT);
        bad_mask = '0;
        run_sweep(1'b0, 1'b1, HEALTHY_LAT);
        clear_faults = 1'b1;
        tick();
        clear_faults = 1'b0;
        m_fault = '0;
        chk("clear_fault_map", 32'(fault_map), 0);
        chk("clear_any_lag", 32'(any_fault), 1);
        tick();
        chk("clear_any", 32'(any_fault), 0);

        // PE0 never completes: every vector waits the full timeout
        stuck_mask = 4'b0001;
        m_fault |= 4'b0001;
        run_sweep(1'b0, 1'b0, STUCK_LAT);
        stuck_mask = '0;

        // Reset in the WAIT of vector 2; next sweep must repeat the power-up vectors
        test_req = 1'b1;
        tick();
        test_req = 1'b0;
        repeat (11) tick();
        chk("pre_rst_busy", 32'(test_busy), 1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        m_lfsr  = SEED;
        m_idx   = 0;
        m_fault = '0;
        @(negedge clk);
        rst = 1'b1;
        run_sweep(1'b0, 1'b0, HEALTHY_LAT);

        // Randomized back-to-back sweeps with test_req held high
        for (int s = 0; s < 50; s++) begin
            int mode;
            mode       = int'($urandom_range(0, 3));
            bad_mask   = ($urandom_range(0, 2) == 0) ? NPE'($urandom_range(1, 15)) : '0;
            bad_vec    = int'($urandom_range(0, NV - 1));
            stuck_mask = ($urandom_range(0, 7) == 0) ? (NPE'(1) << $urandom_range(0, NPE - 1))
                                                     : '0;
            if (mode == 0) begin
                clear_faults = 1'b1;
                m_fault      = '0;
            end
            m_fault |= bad_mask | stuck_mask;
            run_sweep(1'b1, mode == 1, (stuck_mask != '0) ? STUCK_LAT : HEALTHY_LAT);
        end
        test_req   = 1'b0;
        bad_mask   = '0;
        stuck_mask = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
